// File: rtl/ifu_ctrl_if.sv
// Fetch-side bus of ifu_ctrl: instruction-memory port, redirect request,
// decode-facing valid/ready queue head and misalignment pulse.
interface ifu_ctrl_if;
  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign;

  modport master (
    output im_addr, out_valid, out_instr, out_pc, misalign,
    input  im_dout, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  im_addr, out_valid, out_instr, out_pc, misalign,
    output im_dout, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifu_ctrl.sv
// Instruction fetch controller: sequential pc, 2-entry {pc, instr} queue
// towards decode, redirect with flush, registered outputs only.
module ifu_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input logic        clk,
  input logic        rst,
  ifu_ctrl_if.master bus
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] ent_pc_q [2];
  logic [31:0] ent_pc_d [2];
  logic [31:0] ent_instr_q [2];
  logic [31:0] ent_instr_d [2];
  logic        misalign_q, misalign_d;
  logic        pop, push;
  logic [1:0]  rem;

  always_comb begin
    pop         = (count_q != '0) & bus.out_ready;
    push        = ~bus.redirect & ((count_q < FULL_CNT) | pop);
    rem         = count_q - {1'b0, pop};
    pc_d        = pc_q;
    count_d     = count_q;
    ent_pc_d    = ent_pc_q;
    ent_instr_d = ent_instr_q;
    misalign_d  = bus.redirect & (|bus.redirect_pc[1:0]);

    if (bus.redirect) begin
      // Entries are left in place so the head holds its last value while empty.
      count_d = '0;
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (pop && count_q == 2'd2) begin
        ent_pc_d[0]    = ent_pc_q[1];
        ent_instr_d[0] = ent_instr_q[1];
      end
      if (push) begin
        if (rem == 2'd0) begin
          ent_pc_d[0]    = pc_q;
          ent_instr_d[0] = bus.im_dout;
        end else begin
          ent_pc_d[1]    = pc_q;
          ent_instr_d[1] = bus.im_dout;
        end
        pc_d = pc_q + 32'd4;
      end
      count_d = rem + {1'b0, push};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= {RESET_PC[31:2], 2'b00};
      count_q        <= '0;
      ent_pc_q[0]    <= '0;
      ent_pc_q[1]    <= '0;
      ent_instr_q[0] <= '0;
      ent_instr_q[1] <= '0;
      misalign_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      ent_pc_q    <= ent_pc_d;
      ent_instr_q <= ent_instr_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.im_addr   = pc_q[11:2];
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = ent_instr_q[0];
  assign bus.out_pc    = ent_pc_q[0];
  assign bus.misalign  = misalign_q;

endmodule
